// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain controller: state encoding and
// default chain geometry.
package scan_pkg;

   localparam int DEF_CHAIN_LEN  = 8;
   localparam int DEF_CAP_CYCLES = 1;
   localparam int DEF_CNT_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT_IN  = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_SHIFT_OUT = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

endpackage

// File: rtl/scan_piso_sipo.sv
// Pattern/response register: parallel load, MSB-first serial read and
// serial capture, both addressed by a bit index counting up from the MSB.
module scan_piso_sipo
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 load,
   input  logic [CHAIN_LEN-1:0] load_data,
   input  logic                 capture,
   input  logic [CNT_W-1:0]     idx,
   input  logic                 sin,
   output logic [CHAIN_LEN-1:0] data,
   output logic                 sout
);

   logic [CHAIN_LEN-1:0] data_q;

   // NOTE: pure datapath storage is left unreset; the controller masks it
   // with a reset-cleared valid flag, so its power-up contents never escape.
   always_ff @(posedge clk) begin
      if (load) begin
         data_q <= load_data;
      end else if (capture) begin
         for (int i = 0; i < CHAIN_LEN; i++) begin
            if (idx == CNT_W'(CHAIN_LEN - 1 - i)) data_q[i] <= sin;
         end
      end
   end

   // Index 0 addresses the MSB, so counting up walks MSB -> LSB.
   always_comb begin
      sout = 1'b0;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         if (idx == CNT_W'(CHAIN_LEN - 1 - i)) sout = data_q[i];
      end
   end

   assign data = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test controller: shifts a pattern into an external FF_scan chain,
// pulses capture, unloads the response and flags any mismatch.
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
   parameter int CAP_CYCLES = DEF_CAP_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CHAIN_LEN-1:0] pattern_in,
   input  logic [CHAIN_LEN-1:0] expected,
   input  logic                 SO,
   output logic                 SE,
   output logic                 SD,
   output logic                 busy,
   output logic                 done,
   output logic [CHAIN_LEN-1:0] response,
   output logic                 mismatch
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(CAP_CYCLES - 1);

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [CHAIN_LEN-1:0] exp_q;
   logic [CHAIN_LEN-1:0] reg_data;
   logic                 accept;
   logic                 pat_bit;
   logic                 exp_bit;
   logic                 resp_valid;
   logic                 mis_acc;

   assign accept = (state == ST_IDLE) && start;

   // Holds the pattern during shift-in, then is overwritten bit by bit with
   // the unloaded response.
   scan_piso_sipo #(
      .CHAIN_LEN (CHAIN_LEN),
      .CNT_W     (CNT_W)
   ) u_reg (
      .clk       (clk),
      .load      (accept),
      .load_data (pattern_in),
      .capture   (state == ST_SHIFT_OUT),
      .idx       (cnt),
      .sin       (SO),
      .data      (reg_data),
      .sout      (pat_bit)
   );

   always_comb begin
      exp_bit = 1'b0;
      for (int i = 0; i < CHAIN_LEN; i++) begin
         if (cnt == CNT_W'(CHAIN_LEN - 1 - i)) exp_bit = exp_q[i];
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      SE        = 1'b0;
      SD        = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            busy    = 1'b0;
            cnt_nxt = '0;
            if (start) state_nxt = ST_SHIFT_IN;
         end
         ST_SHIFT_IN: begin
            SE = 1'b1;
            SD = pat_bit;
            if (cnt == LAST_BIT) begin
               state_nxt = ST_CAPTURE;
               cnt_nxt   = '0;
            end
         end
         ST_CAPTURE: begin
            if (cnt == LAST_CAP) begin
               state_nxt = ST_SHIFT_OUT;
               cnt_nxt   = '0;
            end
         end
         ST_SHIFT_OUT: begin
            SE = 1'b1;
            if (cnt == LAST_BIT) begin
               state_nxt = ST_DONE;
               cnt_nxt   = '0;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples pre-edge values, matching the flops in the scan chain itself.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         resp_valid <= 1'b0;
         mis_acc    <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            resp_valid <= 1'b0;
            mis_acc    <= 1'b0;
         end else if (state == ST_SHIFT_OUT) begin
            // Compare each bit as it arrives; the OR is complete on entry to DONE.
            mis_acc <= mis_acc | (SO ^ exp_bit);
            if (cnt == LAST_BIT) resp_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) exp_q <= expected;
   end

   assign response = resp_valid ? reg_data : '0;
   assign mismatch = resp_valid & mis_acc;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving an 8-cell FF_scan chain whose
// functional D inputs come from d_func.
module tb_scan_chain_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] pattern_in;
   logic [7:0] expected;
   logic       SO;
   logic       SE;
   logic       SD;
   logic       busy;
   logic       done;
   logic [7:0] response;
   logic       mismatch;
   logic [7:0] d_func;
   logic [7:0] chain_q;

   int checks   = 0;
   int failures = 0;

   scan_chain_ctrl #(
      .CHAIN_LEN  (8),
      .CAP_CYCLES (1),
      .CNT_W      (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pattern_in (pattern_in),
      .expected   (expected),
      .SO         (SO),
      .SE         (SE),
      .SD         (SD),
      .busy       (busy),
      .done       (done),
      .response   (response),
      .mismatch   (mismatch)
   );

   // Chain of FF_scan cells: SD into cell 0, cell i fed by cell i-1.
   always_ff @(posedge clk) begin
      chain_q <= SE ? {chain_q[6:0], SD} : d_func;
   end
   assign SO = chain_q[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge of the
   // first cycle after DONE.
   task automatic run_test(input logic [7:0] pat, input logic [7:0] exp_v,
                           input logic [7:0] dfun, input logic [7:0] want_resp,
                           input logic want_mis, input bit glitch);
      int done_at;
      done_at    = 0;
      pattern_in = pat;
      expected   = exp_v;
      d_func     = dfun;
      start      = 1'b1;
      @(negedge clk);
      pattern_in = ~pat;
      expected   = ~exp_v;
      for (int c = 1; c <= 18; c++) begin
         if (c == 1) begin
            check("resp_clear_on_start", response, 8'h00);
            check("mis_clear_on_start", mismatch, 1'b0);
            check("busy_running", busy, 1'b1);
         end
         if (c <= 8) begin
            check("se_shift_in", SE, 1'b1);
            check("sd_bit", SD, pat[8-c]);
         end
         if (c == 9) begin
            check("se_capture", SE, 1'b0);
            check("chain_loaded", chain_q, pat);
         end
         if (c >= 10 && c <= 17) check("se_shift_out", SE, 1'b1);
         if (done && done_at == 0) done_at = c;
         if (c == 18) begin
            check("done_pulse", done, 1'b1);
            check("busy_done", busy, 1'b1);
            check("se_done", SE, 1'b0);
            check("response", response, want_resp);
            check("mismatch", mismatch, want_mis);
            check("chain_flushed", chain_q, 8'h00);
         end
         start = glitch && (c == 5 || c == 18);
         @(negedge clk);
      end
      start = 1'b0;
      check("done_latency", done_at, 18);
      check("done_one_cycle", done, 1'b0);
      check("busy_back_idle", busy, 1'b0);
   endtask

   initial begin
      int done_cnt;
      reset      = 1'b1;
      start      = 1'b0;
      pattern_in = 8'h00;
      expected   = 8'h00;
      d_func     = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_se", SE, 1'b0);
      check("rst_sd", SD, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_response", response, 8'h00);
      check("rst_mismatch", mismatch, 1'b0);
      @(negedge clk);
      check("idle_busy", busy, 1'b0);

      // Matching capture.
      run_test(8'hA5, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b0);

      // Mismatching capture; result holds through idle cycles.
      run_test(8'hA5, 8'h3D, 8'h3C, 8'h3C, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("hold_response", response, 8'h3C);
         check("hold_mismatch", mismatch, 1'b1);
         @(negedge clk);
      end

      // start while busy (cycle 5 and DONE) is ignored and not queued.
      run_test(8'h5A, 8'h80, 8'h81, 8'h81, 1'b1, 1'b1);
      @(negedge clk);
      check("no_queued_start", busy, 1'b0);
      check("hold_after_glitch", response, 8'h81);

      // Reset in the middle of shift-out aborts the test.
      pattern_in = 8'hA5;
      expected   = 8'h3C;
      d_func     = 8'h3C;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      check("abort_in_shift_out", SE, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_se", SE, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_response", response, 8'h00);
      check("abort_mismatch", mismatch, 1'b0);
      done_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("abort_no_done", done_cnt, 0);

      // Clean run after abort with a different pattern.
      run_test(8'h01, 8'hC3, 8'hC3, 8'hC3, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
